// File: rtl/spi_host_arbiter_if.sv
// Signal bundle between the SPI host engines, the SPI host arbiter and the board SPI pins.
interface spi_host_arbiter_if #(
    parameter int NumReq = 2
);
    localparam int OwW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0] req_i;
    logic [NumReq-1:0] done_i;
    logic [NumReq-1:0] gnt_o;
    logic [NumReq-1:0] host_tx_i;
    logic [NumReq-1:0] host_sck_i;
    logic [NumReq-1:0] host_cs_ni;
    logic [NumReq-1:0] host_rx_o;
    logic              spi_tx_o;
    logic              spi_sck_o;
    logic              spi_cs_no;
    logic              spi_rx_i;
    logic [OwW-1:0]    owner_o;
    logic              busy_o;
    logic              timeout_o;

    // Arbiter side.
    modport slave (
        input  req_i, done_i, host_tx_i, host_sck_i, host_cs_ni, spi_rx_i,
        output gnt_o, host_rx_o, spi_tx_o, spi_sck_o, spi_cs_no, owner_o, busy_o, timeout_o
    );

    // Host engines and pin side.
    modport master (
        output req_i, done_i, host_tx_i, host_sck_i, host_cs_ni, spi_rx_i,
        input  gnt_o, host_rx_o, spi_tx_o, spi_sck_o, spi_cs_no, owner_o, busy_o, timeout_o
    );
endinterface

// File: rtl/spi_host_arbiter.sv
// Round-robin arbiter sharing one SPI port between NumReq hosts, with whole-transaction lock and idle gap.
// Optional grant watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_host_arbiter #(
    parameter int   NumReq        = 2,
    parameter int   GapCycles     = 2,
    parameter logic IdleSck       = 1'b0,
    parameter int   TimeoutCycles = 4096
) (
    input  logic              clk_sys_i,
    input  logic              rst_sys_i,
    spi_host_arbiter_if.slave bus
);
    localparam int OwW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int GapW = 4;

    if (NumReq < 2 || NumReq > 8 || GapCycles < 1 || GapCycles > 15 || TimeoutCycles < 2) begin : g_param_check
        $error("spi_host_arbiter: parameter out of legal range");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_RELEASE} state_t;

    state_t            r_state, w_state_nxt;
    logic [NumReq-1:0] r_gnt, w_gnt_nxt;
    logic [OwW-1:0]    r_owner, w_owner_nxt;
    logic [OwW-1:0]    r_ptr, w_ptr_nxt;
    logic [GapW-1:0]   r_gap, w_gap_nxt;
    logic [OwW-1:0]    w_winner, w_idx, w_owner_inc;
    logic              w_any_req, w_user_exit, w_wdog_exp;
    int                w_tmp;

    // Scan from ptr upward with wrap; the lowest offset from ptr wins.
    always_comb begin
        w_winner  = r_ptr;
        w_any_req = 1'b0;
        w_tmp     = 0;
        w_idx     = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            w_tmp = int'(r_ptr) + i;
            if (w_tmp >= NumReq) w_tmp = w_tmp - NumReq;
            w_idx = OwW'(w_tmp);
            if (bus.req_i[w_idx]) begin
                w_winner  = w_idx;
                w_any_req = 1'b1;
            end
        end
    end

    assign w_owner_inc = (r_owner == OwW'(NumReq - 1)) ? '0 : r_owner + OwW'(1);
    assign w_user_exit = bus.done_i[r_owner] | ~bus.req_i[r_owner];

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WdW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    logic [WdW-1:0] r_wdog;
    logic           r_timeout;

    assign w_wdog_exp    = (r_wdog == WdW'(TimeoutCycles - 1));
    assign bus.timeout_o = r_timeout;

    // Watchdog runs only while a host owns the bus and restarts on every new grant.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wdog    <= (r_state == ST_OWN) ? r_wdog + WdW'(1) : '0;
            r_timeout <= (r_state == ST_OWN) && w_wdog_exp && !w_user_exit;
        end
    end
`else
    assign w_wdog_exp    = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_gap_nxt   = r_gap;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt         = ST_OWN;
                    w_gnt_nxt           = '0;
                    w_gnt_nxt[w_winner] = 1'b1;
                    w_owner_nxt         = w_winner;
                end
            end
            ST_OWN: begin
                if (w_user_exit || w_wdog_exp) begin
                    w_state_nxt = ST_RELEASE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_owner_inc;
                    w_gap_nxt   = GapW'(GapCycles - 1);
                end
            end
            ST_RELEASE: begin
                if (r_gap == '0) w_state_nxt = ST_IDLE;
                else             w_gap_nxt   = r_gap - GapW'(1);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pins follow the owner only in OWN; everywhere else the bus is parked idle.
    always_comb begin
        bus.spi_tx_o  = 1'b0;
        bus.spi_sck_o = IdleSck;
        bus.spi_cs_no = 1'b1;
        bus.host_rx_o = '0;
        if (r_state == ST_OWN) begin
            bus.spi_tx_o           = bus.host_tx_i[r_owner];
            bus.spi_sck_o          = bus.host_sck_i[r_owner];
            bus.spi_cs_no          = bus.host_cs_ni[r_owner];
            bus.host_rx_o[r_owner] = bus.spi_rx_i;
        end
    end

    assign bus.gnt_o   = r_gnt;
    assign bus.owner_o = r_owner;
    assign bus.busy_o  = (r_state != ST_IDLE);
endmodule

// File: tb/tb_spi_host_arbiter.sv
// Bench for spi_host_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_spi_host_arbiter;
    localparam int   N    = 2;
    localparam int   G    = 2;
    localparam int   TC   = 16;
    localparam logic ISCK = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_host_arbiter_if #(.NumReq(N)) bus_a ();
    spi_host_arbiter_if #(.NumReq(4)) bus_b ();

    spi_host_arbiter #(.NumReq(N), .GapCycles(G), .IdleSck(ISCK), .TimeoutCycles(TC)) dut_a (
        .clk_sys_i(clk), .rst_sys_i(rst), .bus(bus_a));
    spi_host_arbiter #(.NumReq(4), .GapCycles(1), .IdleSck(1'b0), .TimeoutCycles(4096)) dut_b (
        .clk_sys_i(clk), .rst_sys_i(rst), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: who owns the bus, how many quiet cycles remain, whose turn is next.
    int   m_own = -1, m_last = 0, m_ptr = 0, m_rel = 0, m_cnt = 0, m_idx;
    bit   m_on = 0, m_to = 0, m_user, m_forced, m_found;
    logic [N-1:0] e_gnt, e_rx;
    logic e_tx, e_sck, e_cs;

    always @(posedge clk) begin
        m_to = 1'b0;
        if (rst) begin
            m_own = -1; m_last = 0; m_ptr = 0; m_rel = 0; m_on = 1'b1;
        end else if (m_own >= 0) begin
            m_user = bus_a.done_i[m_own] || !bus_a.req_i[m_own];
`ifdef SPI_ARB_TIMEOUT_EN
            m_forced = (m_cnt == TC - 1);
`else
            m_forced = 1'b0;
`endif
            if (m_user || m_forced) begin
                m_to  = !m_user;
                m_ptr = (m_own + 1) % N;
                m_own = -1;
                m_rel = G;
            end else begin
                m_cnt++;
            end
        end else if (m_rel > 0) begin
            m_rel--;
        end else begin
            m_found = 1'b0;
            for (int k = 0; k < N; k++) begin
                m_idx = (m_ptr + k) % N;
                if (!m_found && bus_a.req_i[m_idx]) begin
                    m_found = 1'b1; m_own = m_idx; m_last = m_idx; m_cnt = 0;
                end
            end
        end
        #1;
        if (m_on) begin
            e_gnt = '0; e_rx = '0; e_tx = 1'b0; e_sck = ISCK; e_cs = 1'b1;
            if (m_own >= 0) begin
                e_gnt[m_own] = 1'b1;
                e_rx[m_own]  = bus_a.spi_rx_i;
                e_tx  = bus_a.host_tx_i[m_own];
                e_sck = bus_a.host_sck_i[m_own];
                e_cs  = bus_a.host_cs_ni[m_own];
            end
            check("m_gnt", 32'(bus_a.gnt_o), 32'(e_gnt));
            check("m_owner", 32'(bus_a.owner_o), 32'(m_last));
            check("m_busy", 32'(bus_a.busy_o), 32'((m_own >= 0) || (m_rel > 0)));
            check("m_pins", {27'd0, bus_a.spi_tx_o, bus_a.spi_sck_o, bus_a.spi_cs_no, bus_a.host_rx_o},
                  {27'd0, e_tx, e_sck, e_cs, e_rx});
            check("m_timeout", 32'(bus_a.timeout_o), 32'(m_to));
        end
    end

    task automatic wait_gnt_a(output int lows);
        lows = 0;
        while (bus_a.gnt_o == '0 && lows < 50) begin
            lows++;
            @(negedge clk);
        end
        if (bus_a.gnt_o == '0) begin
            checks++; errors++;
            $display("FAIL grant_wait_a: gnt_o still 0 after %0d cycles", lows);
        end
    endtask

    logic [N-1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int lows, n, idx;

    initial begin
        bus_a.req_i = '0; bus_a.done_i = '0; bus_a.host_tx_i = '0; bus_a.host_sck_i = '0;
        bus_a.host_cs_ni = '1; bus_a.spi_rx_i = 1'b0;
        bus_b.req_i = '0; bus_b.done_i = '0; bus_b.host_tx_i = '0; bus_b.host_sck_i = '0;
        bus_b.host_cs_ni = '1; bus_b.spi_rx_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(bus_a.gnt_o), 32'd0);
        check("rst_cs", 32'(bus_a.spi_cs_no), 32'd1);
        check("rst_sck", 32'(bus_a.spi_sck_o), 32'(ISCK));
        check("rst_busy", 32'(bus_a.busy_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // First grant: one cycle latency, pins follow host 0.
        bus_a.req_i = 2'b01; bus_a.host_cs_ni = 2'b10; bus_a.host_tx_i = 2'b01;
        bus_a.host_sck_i = 2'b10; bus_a.spi_rx_i = 1'b1;
        @(negedge clk);
        check("first_gnt", 32'(bus_a.gnt_o), 32'h1);
        check("first_cs", 32'(bus_a.spi_cs_no), 32'd0);
        check("first_tx", 32'(bus_a.spi_tx_o), 32'd1);
        check("first_rx", 32'(bus_a.host_rx_o), 32'h1);

        // Non-owner noise must not disturb the grant or the pins.
        for (int i = 0; i < 3; i++) begin
            bus_a.req_i[1] = ~bus_a.req_i[1]; bus_a.done_i[1] = 1'b1;
            bus_a.host_cs_ni[1] = ~bus_a.host_cs_ni[1];
            @(negedge clk);
            bus_a.done_i[1] = 1'b0; bus_a.spi_rx_i = ~bus_a.spi_rx_i;
            @(negedge clk);
        end
        bus_a.req_i[1] = 1'b0; bus_a.host_cs_ni = 2'b11;
        @(negedge clk);
        check("noise_gnt", 32'(bus_a.gnt_o), 32'h1);
        check("owner_cs_high", 32'(bus_a.spi_cs_no), 32'd1);
        bus_a.host_cs_ni = 2'b10;

        // Lone requester keeps req after done: re-granted after the gap.
        bus_a.done_i[0] = 1'b1;
        @(negedge clk);
        bus_a.done_i[0] = 1'b0;
        wait_gnt_a(lows);
        check("lone_gap", 32'(lows), 32'(G + 1));
        check("lone_regnt", 32'(bus_a.gnt_o), 32'h1);

        // Simultaneous done and req drop, then re-raise during the gap.
        repeat (3) @(negedge clk);
        bus_a.done_i[0] = 1'b1; bus_a.req_i[0] = 1'b0;
        @(negedge clk);
        bus_a.done_i[0] = 1'b0;
        check("simul_rel_busy", 32'(bus_a.busy_o), 32'd1);
        @(negedge clk);
        bus_a.req_i[0] = 1'b1;
        wait_gnt_a(lows);
        check("reraise_gnt", 32'(bus_a.gnt_o), 32'h1);

        // Both requesting: grants alternate, gap between owners.
        bus_a.req_i = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_gnt_a(lows);
            check("rr_gnt", 32'(bus_a.gnt_o), 32'(rr_exp[g]));
            if (g > 0) check("rr_gap", 32'(lows), 32'(G + 1));
            if (g < 3) begin
                repeat (10) @(negedge clk);
                bus_a.done_i = bus_a.gnt_o;
                @(negedge clk);
                bus_a.done_i = '0;
            end
        end

        // Reset while host 1 owns the bus with cs asserted.
        bus_a.host_cs_ni = 2'b01;
        repeat (3) @(negedge clk);
        check("pre_rst_cs", 32'(bus_a.spi_cs_no), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_gnt", 32'(bus_a.gnt_o), 32'd0);
        check("midrst_cs", 32'(bus_a.spi_cs_no), 32'd1);
        check("midrst_owner", 32'(bus_a.owner_o), 32'd0);
        rst = 1'b0;
        wait_gnt_a(lows);
        check("post_rst_gnt", 32'(bus_a.gnt_o), 32'h1);

        // Owner never releases.
        bus_a.req_i = 2'b01;
        n = 0;
        while (bus_a.gnt_o != '0 && n < 120) begin
            n++;
            @(negedge clk);
        end
`ifdef SPI_ARB_TIMEOUT_EN
        check("hold_len", 32'(n), 32'(TC));
        check("to_pulse", 32'(bus_a.timeout_o), 32'd1);
        @(negedge clk);
        check("to_pulse_end", 32'(bus_a.timeout_o), 32'd0);
`else
        check("hold_len", 32'(n), 32'd120);
        check("hold_gnt", 32'(bus_a.gnt_o), 32'h1);
`endif
        bus_a.req_i = '0;
        repeat (5) @(negedge clk);

        // Four hosts, release by req drop: order 0,1,2,3,0.
        bus_b.req_i = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (bus_b.gnt_o == '0 && n < 50) begin
                n++;
                @(negedge clk);
            end
            idx = -1;
            for (int k = 0; k < 4; k++) if (bus_b.gnt_o == (4'b0001 << k)) idx = k;
            check("rr4_order", 32'(idx), 32'(g % 4));
            if (idx < 0) break;
            repeat (2) @(negedge clk);
            bus_b.req_i[idx] = 1'b0;
            @(negedge clk);
            bus_b.req_i[idx] = 1'b1;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
